vector_writeback_sequencer: RTL and testbench

Writer-side companion to the register files: accepts completed writeback results from the pipeline and drives them, one 32-bit lane per cycle, onto the register-file write port (address, data, write enable). Scalar results take a single beat; 128-bit vector results (AES state) are serialised into up to four lane writes. Sits between the writeback stage and the decode-stage register files, and gives the pipeline a valid/ready handshake plus a busy indication for stall control.

---
 rtl/vector_writeback_sequencer_pkg.sv | 33 +++
 rtl/vector_writeback_sequencer_if.sv | 39 +++
 rtl/vector_writeback_sequencer_lane_priority_picker.sv | 29 ++
 rtl/vector_writeback_sequencer.sv | 174 +++++++++++++++++
 tb/tb_vector_writeback_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vector_writeback_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// vwb_pkg
// Shared constants and types for the vector writeback sequencer.
//   DATA_W      : lane / scalar word width
//   LANES       : lanes per vector register
//   ADDR_W      : register address width (bit VEC_SEL_BIT selects vector file)
//   LANE_W      : width of a lane index
//   ZERO_REG    : architectural zero register, never written
//   vwb_state_e : sequencer FSM states
// Optional feature macro used by the design: VWB_LANE_MASK_EN.
// -----------------------------------------------------------------------------
package vwb_pkg;
    localparam int DATA_W      = 32;
    localparam int LANES       = 4;
    localparam int ADDR_W      = 5;
    localparam int LANE_W      = 2;
    localparam int VEC_SEL_BIT = 4;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BEAT = 1'b1
    } vwb_state_e;

    // Extract one lane word from a packed vector result.
    function automatic logic [DATA_W-1:0] lane_word(
        input logic [LANES*DATA_W-1:0] vec,
        input logic [LANE_W-1:0]       lane
    );
        lane_word = vec[lane*DATA_W +: DATA_W];
    endfunction
endpackage

// File: rtl/vector_writeback_sequencer_if.sv
// -----------------------------------------------------------------------------
// vector_writeback_sequencer_if
// Bundles the writeback request handshake and the register-file write port.
//   master : pipeline / producer side (drives requests, observes writes)
//   slave  : sequencer side (accepts requests, drives the write port)
// Signals:
//   req_valid/req_ready  request handshake
//   req_addr/req_vec/req_data/req_mask  request payload
//   wr_en/wr_addr/wr_lane/wr_data/wr_vec  register-file write beat
//   busy  beats outstanding, last  final beat of a request
// -----------------------------------------------------------------------------
interface vector_writeback_sequencer_if;
    import vwb_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_W-1:0]       req_addr;
    logic                    req_vec;
    logic [LANES*DATA_W-1:0] req_data;
    logic [LANES-1:0]        req_mask;

    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [LANE_W-1:0]       wr_lane;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_vec;
    logic                    busy;
    logic                    last;

    modport master (
        output req_valid, req_addr, req_vec, req_data, req_mask,
        input  req_ready, wr_en, wr_addr, wr_lane, wr_data, wr_vec, busy, last
    );

    modport slave (
        input  req_valid, req_addr, req_vec, req_data, req_mask,
        output req_ready, wr_en, wr_addr, wr_lane, wr_data, wr_vec, busy, last
    );
endinterface

// File: rtl/vector_writeback_sequencer_lane_priority_picker.sv
// -----------------------------------------------------------------------------
// lane_priority_picker
// Combinational: selects the lowest set lane of a mask.
//   i_mask  : remaining lane mask
//   o_lane  : index of the lowest set bit (0 when mask is empty)
//   o_valid : mask has at least one bit set
//   o_rest  : mask with the selected bit cleared
// -----------------------------------------------------------------------------
module lane_priority_picker
    import vwb_pkg::*;
(
    input  logic [LANES-1:0]  i_mask,
    output logic [LANE_W-1:0] o_lane,
    output logic              o_valid,
    output logic [LANES-1:0]  o_rest
);

    // Lowest-set-bit search; scanning downward lets the lowest hit win.
    always_comb begin
        o_lane = {LANE_W{1'b0}};
        for (int i = LANES - 1; i >= 0; i--) begin
            o_lane = i_mask[i] ? LANE_W'(i) : o_lane;
        end
        o_valid = |i_mask;
        // x & (x-1) clears exactly the lowest set bit.
        o_rest  = i_mask & (i_mask - {{(LANES-1){1'b0}}, 1'b1});
    end

endmodule

// File: rtl/vector_writeback_sequencer.sv
// -----------------------------------------------------------------------------
// vector_writeback_sequencer
// Accepts completed writeback results and drives them one 32-bit lane per
// cycle onto the register-file write port. Scalars take one beat; vector
// results issue one beat per enabled lane in ascending order.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset
//   srst  : synchronous soft reset (active high)
//   bus   : request handshake + write port (slave modport)
// Configuration: define VWB_LANE_MASK_EN to honour req_mask; otherwise every
// vector request writes all LANES lanes.
// -----------------------------------------------------------------------------
module vector_writeback_sequencer
    import vwb_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          srst,
    vector_writeback_sequencer_if.slave   bus
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_BEAT = BEAT;

    logic [0:0]              r_state;
    logic                    r_alive;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_vec;
    logic [LANES*DATA_W-1:0] r_data;
    logic [LANES-1:0]        r_rem;

    logic                    r_wr_en;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [LANE_W-1:0]       r_wr_lane;
    logic [DATA_W-1:0]       r_wr_data;
    logic                    r_wr_vec;
    logic                    r_last;

    logic                    w_ready;
    logic                    w_accept;
    logic [LANES-1:0]        w_mask_eff;
    logic [LANES-1:0]        w_pick_mask;
    logic [LANE_W-1:0]       w_pick_lane;
    logic                    w_pick_valid;
    logic [LANES-1:0]        w_pick_rest;
    logic [ADDR_W-1:0]       w_src_addr;
    logic                    w_src_vec;
    logic [LANES*DATA_W-1:0] w_src_data;
    logic                    w_we;

`ifdef VWB_LANE_MASK_EN
    assign w_mask_eff = bus.req_mask;
`else
    logic w_unused_mask;
    assign w_mask_eff    = {LANES{1'b1}};
    assign w_unused_mask = ^bus.req_mask;
`endif

    // Ready: held low until the first edge out of reset, then open in IDLE
    // and on the final beat so back-to-back requests see no bubble.
    always_comb begin
        if (!r_alive) begin
            w_ready = 1'b0;
        end else if (r_state == S_BEAT) begin
            w_ready = r_last;
        end else begin
            w_ready = 1'b1;
        end
    end

    assign w_accept = bus.req_valid & w_ready;

    // Beat source: a transferring request feeds the first beat straight from
    // the inputs; otherwise continue from the captured request.
    always_comb begin
        w_src_addr  = r_addr;
        w_src_vec   = r_vec;
        w_src_data  = r_data;
        w_pick_mask = {LANES{1'b0}};
        if (w_accept) begin
            w_src_addr  = bus.req_addr;
            w_src_vec   = bus.req_vec;
            w_src_data  = bus.req_data;
            w_pick_mask = bus.req_vec ? w_mask_eff : {{(LANES-1){1'b0}}, 1'b1};
        end else if (r_state == S_BEAT) begin
            w_pick_mask = r_rem;
        end else begin
            w_pick_mask = {LANES{1'b0}};
        end
    end

    // Scalar writes to the zero register still take a beat but never strobe.
    assign w_we = w_src_vec | (w_src_addr != ZERO_REG);

    lane_priority_picker u_picker (
        .i_mask  (w_pick_mask),
        .o_lane  (w_pick_lane),
        .o_valid (w_pick_valid),
        .o_rest  (w_pick_rest)
    );

    // Sequencer state, request capture and registered write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_alive   <= 1'b0;
            r_addr    <= {ADDR_W{1'b0}};
            r_vec     <= 1'b0;
            r_data    <= {(LANES*DATA_W){1'b0}};
            r_rem     <= {LANES{1'b0}};
            r_wr_en   <= 1'b0;
            r_wr_addr <= {ADDR_W{1'b0}};
            r_wr_lane <= {LANE_W{1'b0}};
            r_wr_data <= {DATA_W{1'b0}};
            r_wr_vec  <= 1'b0;
            r_last    <= 1'b0;
        end else if (srst) begin
            r_state   <= S_IDLE;
            r_alive   <= 1'b0;
            r_addr    <= {ADDR_W{1'b0}};
            r_vec     <= 1'b0;
            r_data    <= {(LANES*DATA_W){1'b0}};
            r_rem     <= {LANES{1'b0}};
            r_wr_en   <= 1'b0;
            r_wr_addr <= {ADDR_W{1'b0}};
            r_wr_lane <= {LANE_W{1'b0}};
            r_wr_data <= {DATA_W{1'b0}};
            r_wr_vec  <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_addr <= bus.req_addr;
                r_vec  <= bus.req_vec;
                r_data <= bus.req_data;
            end else begin
                r_addr <= r_addr;
                r_vec  <= r_vec;
                r_data <= r_data;
            end
            if (w_pick_valid) begin
                r_state   <= S_BEAT;
                r_rem     <= w_pick_rest;
                r_wr_en   <= w_we;
                r_wr_addr <= w_src_addr;
                r_wr_lane <= w_pick_lane;
                r_wr_data <= lane_word(w_src_data, w_pick_lane);
                r_wr_vec  <= w_src_vec;
                r_last    <= (w_pick_rest == {LANES{1'b0}});
            end else begin
                // Nothing left (or an empty-mask vector was dropped).
                r_state   <= S_IDLE;
                r_rem     <= {LANES{1'b0}};
                r_wr_en   <= 1'b0;
                r_wr_addr <= {ADDR_W{1'b0}};
                r_wr_lane <= {LANE_W{1'b0}};
                r_wr_data <= {DATA_W{1'b0}};
                r_wr_vec  <= 1'b0;
                r_last    <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_lane   = r_wr_lane;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_vec    = r_wr_vec;
    assign bus.busy      = (r_state == S_BEAT);
    assign bus.last      = r_last;

endmodule

// File: tb/tb_vector_writeback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_writeback_sequencer
// Directed bench with a beat scoreboard: expected beats are queued when a
// request is seen to transfer and checked one per cycle as the DUT issues them.
// -----------------------------------------------------------------------------
module tb_vector_writeback_sequencer;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [1:0]  lane;
        logic [31:0] data;
        logic        vec;
        logic        last;
    } beat_t;

    logic clk;
    logic rst;
    logic srst;

    vector_writeback_sequencer_if bus ();

    vector_writeback_sequencer dut (
        .clk  (clk),
        .rst  (rst),
        .srst (srst),
        .bus  (bus)
    );

    beat_t q[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    n_last_beats = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Reference model: expand a request into the beats it must produce.
    function automatic int push_model(input logic [4:0] a, input logic v,
                                      input logic [127:0] d, input logic [3:0] m);
        beat_t      b;
        logic [3:0] me;
        int         n = 0;
        if (!v) begin
            b.en = (a != 5'd0); b.addr = a; b.lane = 2'd0;
            b.data = d[31:0]; b.vec = 1'b0; b.last = 1'b1;
            q.push_back(b);
            n = 1;
        end else begin
`ifdef VWB_LANE_MASK_EN
            me = m;
`else
            me = 4'hF;
`endif
            for (int i = 0; i < 4; i++) begin
                if (me[i]) begin
                    b.en = 1'b1; b.addr = a; b.lane = i[1:0];
                    b.data = d[i*32 +: 32]; b.vec = 1'b1; b.last = 1'b1;
                    for (int j = i + 1; j < 4; j++) begin
                        if (me[j]) b.last = 1'b0;
                    end
                    q.push_back(b);
                    n++;
                end
            end
        end
        return n;
    endfunction

    // Present a request from the next falling edge until it transfers.
    task automatic send(input logic [4:0] a, input logic v,
                        input logic [127:0] d, input logic [3:0] m);
        int waited = 0;
        bit done = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_vec   = v;
        bus.req_data  = d;
        bus.req_mask  = m;
        while (!done) begin
            if (bus.req_ready === 1'b1) begin
                n_last_beats = push_model(a, v, d, m);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    check("send_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        @(posedge clk);
        #1;
        // Inputs become don't-care once captured; scramble them.
        bus.req_valid = 1'b0;
        bus.req_addr  = 5'($urandom);
        bus.req_vec   = 1'($urandom);
        bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.req_mask  = 4'($urandom);
    endtask

    task automatic drain();
        int waited = 0;
        while (q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Beat monitor: sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        beat_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("beat_busy", 32'(bus.busy),    32'd1);
            check("beat_en",   32'(bus.wr_en),   32'(e.en));
            check("beat_addr", 32'(bus.wr_addr), 32'(e.addr));
            check("beat_lane", 32'(bus.wr_lane), 32'(e.lane));
            check("beat_data", bus.wr_data,      e.data);
            check("beat_vec",  32'(bus.wr_vec),  32'(e.vec));
            check("beat_last", 32'(bus.last),    32'(e.last));
        end else begin
            check("idle_wr_en", 32'(bus.wr_en), 32'd0);
            check("idle_busy",  32'(bus.busy),  32'd0);
        end
    end

    initial begin
        rst  = 1'b0;
        srst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 5'd0;
        bus.req_vec   = 1'b0;
        bus.req_data  = 128'd0;
        bus.req_mask  = 4'd0;

        // Reset held over three edges with random inputs.
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 1'($urandom);
            bus.req_addr  = 5'($urandom);
            bus.req_vec   = 1'($urandom);
            bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.req_mask  = 4'($urandom);
            @(posedge clk);
            #1;
            check("rst_wr_en",   32'(bus.wr_en),     32'd0);
            check("rst_wr_addr", 32'(bus.wr_addr),   32'd0);
            check("rst_wr_lane", 32'(bus.wr_lane),   32'd0);
            check("rst_wr_data", bus.wr_data,        32'd0);
            check("rst_wr_vec",  32'(bus.wr_vec),    32'd0);
            check("rst_busy",    32'(bus.busy),      32'd0);
            check("rst_last",    32'(bus.last),      32'd0);
            check("rst_ready",   32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("ready_at_release", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(bus.req_ready), 32'd1);

        // Scalar to r5, then scalar to the zero register.
        send(5'd5, 1'b0, {96'd0, 32'hDEADBEEF}, 4'h0);
        check("scalar_count", 32'(n_last_beats), 32'd1);
        drain();
        check("scalar_ready_after", 32'(bus.req_ready), 32'd1);
        send(5'd0, 1'b0, {96'd0, 32'hCAFEF00D}, 4'h0);
        drain();

        // Vector, full mask.
        send(5'h12, 1'b1, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'hF);
        drain();

        // Vector, sparse mask (lanes 1 and 3 when masking is enabled).
        send(5'h13, 1'b1, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 4'b1010);
        drain();

        // Vector, empty mask: dropped when masking is enabled.
        send(5'h14, 1'b1, {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0}, 4'b0000);
        check("zero_mask_busy",  32'(bus.busy),      32'(n_last_beats > 0));
        check("zero_mask_ready", 32'(bus.req_ready), 32'(n_last_beats <= 1));
        drain();

        // Back-to-back: scalar held valid during a vector, no gap allowed.
        send(5'h15, 1'b1, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0}, 4'hF);
        send(5'd7, 1'b0, {96'd0, 32'h0BADC0DE}, 4'h0);
        drain();

        // Reset after the second beat of a full vector.
        send(5'h16, 1'b1, {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0}, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        q.delete();
        check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
        check("midrst_busy",  32'(bus.busy),  32'd0);
        check("midrst_data",  bus.wr_data,    32'd0);
        check("midrst_last",  32'(bus.last),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(5'd9, 1'b0, {96'd0, 32'h12345678}, 4'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
